// File: rtl/mixer_symbol_sequencer.sv
// Frames FIFO-buffered ternary symbols as preamble + data + guard and
// drives the carrier mixer select/enable, holding each symbol for sps clocks.
module mixer_symbol_sequencer #(
  parameter int PRE_LEN    = 8,
  parameter int GUARD_LEN  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] sps,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       mix_en,
  output logic [1:0] mix_din,
  output logic       sym_tick,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic       sym_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] GRD_LAST = 8'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  logic [1:0] state;
  logic [7:0] clk_cnt;
  logic [7:0] sym_cnt;
  logic [7:0] len_q;
  logic [7:0] sps_q;
  logic       fin;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic       empty;
  logic [1:0] head;
  logic       push;
  logic       pop;
  logic       slot;
  logic       sym_last;
  logic       phase_last;
  logic       accept;
  logic       reject;

  logic       nx_en;
  logic [1:0] nx_din;
  logic       nx_tick;
  logic       nx_busy;
  logic       nx_und;
  logic       nx_err;

  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign push      = sym_valid & sym_ready;
  assign slot      = (state == S_DATA) && (clk_cnt == 8'd0);
  assign pop       = slot & ~empty;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign sym_last  = (clk_cnt == sps_q - 8'd1);
  assign accept    = start && (state == S_IDLE) &&
                     (frame_len != 8'd0) && (sps != 8'd0);
  assign reject    = start && (state == S_IDLE) &&
                     ((frame_len == 8'd0) || (sps == 8'd0));

  always_comb begin
    phase_last = 1'b0;
    case (state)
      S_PRE:   phase_last = (sym_cnt == PRE_LAST);
      S_DATA:  phase_last = (sym_cnt == len_q - 8'd1);
      S_GUARD: phase_last = (sym_cnt == GRD_LAST);
      default: phase_last = 1'b0;
    endcase
  end

  // What the mixer sees on the next clock; select 2'b10 is never produced.
  always_comb begin
    nx_en   = 1'b0;
    nx_din  = 2'b00;
    nx_tick = 1'b0;
    nx_busy = 1'b0;
    nx_und  = underrun;
    nx_err  = sym_err;
    if (state != S_IDLE) begin
      nx_en   = 1'b1;
      nx_busy = 1'b1;
      nx_tick = (clk_cnt == 8'd0);
    end
    case (state)
      S_PRE: nx_din = sym_cnt[0] ? 2'b11 : 2'b01;
      S_DATA: begin
        if (slot) begin
          if (empty)
            nx_und = 1'b1;
          else if (head == 2'b10)
            nx_err = 1'b1;
          else
            nx_din = head;
        end else begin
          nx_din = mix_din;
        end
      end
      default: nx_din = 2'b00;
    endcase
    if (accept) begin
      nx_und = 1'b0;
      nx_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= 8'd0;
      sym_cnt <= 8'd0;
      len_q   <= 8'd0;
      sps_q   <= 8'd0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          state   <= S_PRE;
          len_q   <= frame_len;
          sps_q   <= sps;
          clk_cnt <= 8'd0;
          sym_cnt <= 8'd0;
        end
      end else if (!sym_last) begin
        clk_cnt <= clk_cnt + 8'd1;
      end else begin
        clk_cnt <= 8'd0;
        if (!phase_last) begin
          sym_cnt <= sym_cnt + 8'd1;
        end else begin
          sym_cnt <= 8'd0;
          if (state == S_PRE) begin
            state <= S_DATA;
          end else if ((state == S_DATA) && (GUARD_LEN > 0)) begin
            state <= S_GUARD;
          end else begin
            state <= S_IDLE;
            fin   <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_en    <= 1'b0;
      mix_din   <= 2'b00;
      sym_tick  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      sym_err   <= 1'b0;
      sym_ready <= 1'b1;
    end else begin
      mix_en    <= nx_en;
      mix_din   <= nx_din;
      sym_tick  <= nx_tick;
      busy      <= nx_busy;
      done      <= fin | reject;
      underrun  <= nx_und;
      sym_err   <= nx_err;
      sym_ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sym_in;
  end

endmodule
